// File: rtl/fetch_unit_r32i.sv
// -----------------------------------------------------------------------------
// fetch_unit_r32i
// Instruction fetch stage feeding the RV32I decoder. Holds the PC and issues
// word requests to instruction memory, with at most one request in flight.
// Returned {address, instruction} pairs go into a 2-entry buffer. The buffer
// head is offered to the decoder through a valid/ready handshake. A redirect
// (taken branch/jump) replaces the PC and flushes the buffer. If a request is
// still in flight, its response is marked for discard.
//
// Ports
//   clock        : system clock, all state changes on the rising edge
//   reset        : synchronous, active-high reset
//   ImemAddr     : request address (always equals the PC)
//   ImemReq      : request strobe; memory samples ImemAddr when high
//   ImemData     : returned instruction word
//   ImemValid    : ImemData valid
//   Redirect     : taken branch/jump; load RedirectAddr and flush
//   RedirectAddr : new PC, low two bits forced to zero
//   InsOut       : buffer head instruction (NOP when empty)
//   InsAddr      : address of InsOut (zero when empty)
//   InsValid     : buffer head valid
//   InsReady     : decoder accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_unit_r32i #(
    parameter int                dataW     = 32,
    parameter logic [dataW-1:0]  ResetAddr = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    output logic [dataW-1:0] ImemAddr,
    output logic             ImemReq,
    input  logic [dataW-1:0] ImemData,
    input  logic             ImemValid,
    input  logic             Redirect,
    input  logic [dataW-1:0] RedirectAddr,
    output logic [dataW-1:0] InsOut,
    output logic [dataW-1:0] InsAddr,
    output logic             InsValid,
    input  logic             InsReady
);

    localparam logic [dataW-1:0] NopIns = 32'h0000_0013;

    // Architectural state
    logic [dataW-1:0] pc_q, pc_d;
    logic [dataW-1:0] req_addr_q, req_addr_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic [1:0]       count_q, count_d;
    logic             head_q, head_d;
    logic [dataW-1:0] fifo_addr_q [2];
    logic [dataW-1:0] fifo_addr_d [2];
    logic [dataW-1:0] fifo_ins_q  [2];
    logic [dataW-1:0] fifo_ins_d  [2];

    // Per-cycle control terms
    logic             head_valid_s;
    logic             pop_s;
    logic             accept_s;
    logic             push_s;
    logic [1:0]       occ_s;
    logic             issue_s;
    logic             wr_idx_s;

    // Handshake and issue decisions for the current cycle
    always_comb begin
        head_valid_s = (count_q != 2'd0);
        pop_s        = head_valid_s && !reset && InsReady;
        accept_s     = ImemValid && outstanding_q;
        push_s       = accept_s && !discard_q;
        // Occupancy after this edge's pop/push. It reaches 3 only if a push
        // hits a full buffer, which the issue gate makes unreachable.
        occ_s        = count_q - {1'b0, pop_s} + {1'b0, push_s};
        issue_s      = !reset && !Redirect && (!outstanding_q || accept_s)
                       && (occ_s < 2'd2);
        // The next free slot sits just past the head (count is 0 or 1 here).
        wr_idx_s     = head_q ^ count_q[0];
    end

    // Output drive: PC, request strobe and buffer head
    always_comb begin
        ImemAddr = pc_q;
        ImemReq  = issue_s;
        InsValid = head_valid_s && !reset;
        if (head_valid_s) begin
            InsOut  = fifo_ins_q[head_q];
            InsAddr = fifo_addr_q[head_q];
        end else begin
            InsOut  = NopIns;
            InsAddr = '0;
        end
    end

    // Next-state computation; redirect overrides any push/pop/issue
    always_comb begin
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        head_d        = head_q;
        fifo_addr_d   = fifo_addr_q;
        fifo_ins_d    = fifo_ins_q;
        if (Redirect) begin
            pc_d    = {RedirectAddr[dataW-1:2], 2'b00};
            count_d = 2'd0;
            // A response landing now is simply dropped. If it is still in
            // flight, remember to drop it when it returns.
            outstanding_d = outstanding_q && !ImemValid;
            discard_d     = outstanding_q && !ImemValid;
        end else begin
            if (push_s) begin
                fifo_addr_d[wr_idx_s] = req_addr_q;
                fifo_ins_d[wr_idx_s]  = ImemData;
            end else begin
                fifo_addr_d = fifo_addr_q;
            end
            if (pop_s) begin
                head_d = ~head_q;
            end else begin
                head_d = head_q;
            end
            count_d = occ_s;
            if (accept_s) begin
                outstanding_d = 1'b0;
                discard_d     = 1'b0;
            end else begin
                discard_d = discard_q;
            end
            if (issue_s) begin
                req_addr_d    = pc_q;
                pc_d          = pc_q + 32'd4;
                outstanding_d = 1'b1;
            end else begin
                pc_d = pc_q;
            end
        end
    end

    // State register with synchronous reset; buffer payload needs no reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= ResetAddr;
            req_addr_q    <= ResetAddr;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            head_q        <= head_d;
        end
        fifo_addr_q <= fifo_addr_d;
        fifo_ins_q  <= fifo_ins_d;
    end

endmodule

// File: tb/tb_fetch_unit_r32i.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit_r32i
// Self-checking bench for fetch_unit_r32i. A behavioural model tracks the PC,
// the single in-flight request and the buffer contents as a queue. The bench
// predicts every output each cycle. A consumer scoreboard checks the order of
// accepted instructions. A simple memory answers each request with
// addr ^ 32'hA5A5_0000 after a configurable latency.
// -----------------------------------------------------------------------------
module tb_fetch_unit_r32i;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] TAG        = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ImemAddr;
    logic        ImemReq;
    logic [31:0] ImemData;
    logic        ImemValid;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic [31:0] InsOut;
    logic [31:0] InsAddr;
    logic        InsValid;
    logic        InsReady;

    fetch_unit_r32i #(.dataW(32), .ResetAddr(RESET_ADDR)) dut (
        .clock        (clock),
        .reset        (reset),
        .ImemAddr     (ImemAddr),
        .ImemReq      (ImemReq),
        .ImemData     (ImemData),
        .ImemValid    (ImemValid),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .InsOut       (InsOut),
        .InsAddr      (InsAddr),
        .InsValid     (InsValid),
        .InsReady     (InsReady)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    // behavioural model
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    bit          m_busy;
    bit          m_stale;
    logic [63:0] m_buf [$];
    bit          m_known = 1'b0;
    logic [31:0] sb_next;

    // memory model
    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q [$];
    int    lat           = 1;
    bit    lat_rand      = 1'b0;
    bit    keep_on_reset = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One clock cycle: drive memory, check outputs, advance the model.
    task automatic step();
        bit          e_valid, e_pop, e_acc, e_push, e_req, d_req;
        int          occ;
        logic [31:0] e_out, e_addr, d_addr;

        ImemValid = 1'b0;
        ImemData  = $urandom;
        while (mem_q.size() > 0 && mem_q[0].due < cyc) void'(mem_q.pop_front());
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            ImemValid = 1'b1;
            ImemData  = mem_q[0].addr ^ TAG;
            void'(mem_q.pop_front());
        end
        #2;

        e_valid = !reset && (m_buf.size() != 0);
        e_pop   = e_valid && InsReady;
        e_acc   = ImemValid && m_busy;
        e_push  = e_acc && !m_stale;
        occ     = m_buf.size() - int'(e_pop) + int'(e_push);
        e_req   = !reset && !Redirect && (!m_busy || e_acc) && (occ < 2);
        e_out   = (m_buf.size() != 0) ? m_buf[0][31:0]  : 32'h0000_0013;
        e_addr  = (m_buf.size() != 0) ? m_buf[0][63:32] : 32'h0000_0000;

        if (m_known) begin
            chk("ImemReq",  {31'd0, ImemReq},  {31'd0, e_req});
            chk("ImemAddr", ImemAddr, m_pc);
            chk("InsValid", {31'd0, InsValid}, {31'd0, e_valid});
            chk("InsOut",   InsOut,  e_out);
            chk("InsAddr",  InsAddr, e_addr);
            if (InsValid && InsReady && !Redirect && !reset) begin
                chk("pop_addr", InsAddr, sb_next);
                chk("pop_data", InsOut, sb_next ^ TAG);
                sb_next = sb_next + 32'd4;
            end
        end
        d_req  = ImemReq;
        d_addr = ImemAddr;

        @(posedge clock);
        if (reset) begin
            m_pc    = RESET_ADDR;
            m_busy  = 1'b0;
            m_stale = 1'b0;
            m_buf.delete();
            sb_next = RESET_ADDR;
            m_known = 1'b1;
            if (!keep_on_reset) mem_q.delete();
        end else if (Redirect) begin
            m_pc    = {RedirectAddr[31:2], 2'b00};
            m_buf.delete();
            m_stale = m_busy && !ImemValid;
            m_busy  = m_stale;
            sb_next = m_pc;
        end else begin
            if (e_pop)  void'(m_buf.pop_front());
            if (e_push) m_buf.push_back({m_req_addr, ImemData});
            if (e_acc) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            if (e_req) begin
                m_req_addr = m_pc;
                m_pc       = m_pc + 32'd4;
                m_busy     = 1'b1;
            end
        end
        if (d_req) mem_q.push_back('{addr: d_addr, due: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat)});
        cyc++;
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        Redirect     = 1'b0;
        RedirectAddr = 32'h0000_0000;
        InsReady     = 1'b1;
        ImemValid    = 1'b0;
        ImemData     = 32'h0000_0000;
        #1;

        // 1-cycle memory, decoder always ready: one instruction per cycle
        step(); step();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin
                chk("stream_first_valid", {31'd0, InsValid}, 32'd1);
                chk("stream_first_addr", InsAddr, 32'h0000_0000);
                chk("stream_first_ins", InsOut, 32'hA5A5_0000);
            end
            if (k == 3) chk("stream_pc", ImemAddr, 32'h0000_000C);
            if (k == 5) begin
                chk("stream_addr5", InsAddr, 32'h0000_000C);
                chk("stream_ins5", InsOut, 32'hA5A5_000C);
            end
            step();
        end

        // decoder stalled: buffer fills with 0 and 4, requests stop at 8
        reset = 1'b1; InsReady = 1'b0; step();
        reset = 1'b0;
        repeat (8) step();
        chk("stall_valid", {31'd0, InsValid}, 32'd1);
        chk("stall_head_addr", InsAddr, 32'h0000_0000);
        chk("stall_head_ins", InsOut, 32'hA5A5_0000);
        chk("stall_pc", ImemAddr, 32'h0000_0008);
        InsReady = 1'b1; step();
        chk("stall_second_addr", InsAddr, 32'h0000_0004);
        repeat (6) step();

        // 3-cycle memory with a bursty decoder
        reset = 1'b1; lat = 3; step();
        reset = 1'b0;
        repeat (30) begin
            InsReady = $urandom_range(0, 1) != 0;
            step();
        end

        // redirect while the request for 0x8 is in flight
        reset = 1'b1; InsReady = 1'b1; step();
        reset = 1'b0;
        repeat (7) step();
        chk("inflight_cnt", mem_q.size(), 32'd1);
        if (mem_q.size() > 0) chk("inflight_addr", mem_q[0].addr, 32'h0000_0008);
        Redirect = 1'b1; RedirectAddr = 32'h0000_0103; step();
        Redirect = 1'b0;
        chk("redir_pc", ImemAddr, 32'h0000_0100);
        chk("redir_flush", {31'd0, InsValid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (InsValid) break;
            step();
        end
        chk("redir_first_addr", InsAddr, 32'h0000_0100);
        chk("redir_first_ins", InsOut, 32'hA5A5_0100);
        repeat (8) step();

        // redirect in the same cycle as the response
        lat = 2;
        for (int i = 0; i < 20; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due == cyc) break;
            step();
        end
        Redirect = 1'b1; RedirectAddr = 32'h0000_0200; step();
        Redirect = 1'b0;
        chk("same_cycle_pc", ImemAddr, 32'h0000_0200);
        chk("same_cycle_flush", {31'd0, InsValid}, 32'd0);
        repeat (10) step();

        // PC wrap at the top of the address space
        lat = 1;
        Redirect = 1'b1; RedirectAddr = 32'hFFFF_FFFE; step();
        Redirect = 1'b0;
        chk("wrap_pc_top", ImemAddr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc_zero", ImemAddr, 32'h0000_0000);
        repeat (4) step();

        // reset while a response is pending; the late response must be ignored
        lat = 3;
        Redirect = 1'b1; RedirectAddr = 32'h0000_0040; step();
        Redirect = 1'b0; step();
        keep_on_reset = 1'b1;
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rst_pc", ImemAddr, RESET_ADDR);
        chk("rst_valid", {31'd0, InsValid}, 32'd0);
        Redirect = 1'b1; RedirectAddr = 32'h0000_0000;
        repeat (3) step();
        Redirect = 1'b0;
        keep_on_reset = 1'b0;
        chk("late_ignored", {31'd0, InsValid}, 32'd0);
        repeat (6) step();

        // randomized traffic
        lat_rand = 1'b1;
        repeat (400) begin
            reset        = ($urandom_range(0, 99) == 0);
            Redirect     = !reset && ($urandom_range(0, 19) == 0);
            RedirectAddr = $urandom;
            InsReady     = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; Redirect = 1'b0; InsReady = 1'b1;
        repeat (8) step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
